instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, ack-wait limit in cycles (used only with SEQUENCER_TIMEOUT_EN).
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Run  in  1  level enable; high lets the sequencer start new instructions.
REQ-005 MemAck  in  1  memory handshake acknowledge, valid only in FETCH/MEMORY.
REQ-006 InvalidInstruction  in  1  decoder invalid-instruction flag.
REQ-007 IsMemoryRead  in  1  decoder load flag.
REQ-008 IsMemoryWrite  in  1  decoder store flag.
REQ-009 IsBranch  in  1  decoder branch flag.
REQ-010 IsJump  in  1  decoder JAL/JALR flag.
REQ-011 BranchTaken  in  1  comparator result for the current branch.
REQ-012 WritesRegisterFile  in  1  decoder register-write flag.
REQ-013 MemReq  out  1  memory request, held until MemAck.
REQ-014 MemWrite  out  1  request is a store.
REQ-015 MemAddrSelect  out  1  0 = PC, 1 = ALU result.
REQ-016 InstructionLatch  out  1  load instruction register this cycle.
REQ-017 PCWrite  out  1  update PC this cycle.
REQ-018 PCSelect  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
REQ-019 RegWrite  out  1  register-file write enable.
REQ-020 Trap  out  1  sticky fault indicator.
REQ-021 TrapCause  out  1  0 = invalid instruction, 1 = memory timeout.
REQ-022 State  out  3  current state encoding.
REQ-023 RetiredCount  out  32  retired-instruction counter.

Function
REQ-024 States and encoding SHALL be: IDLE=0, FETCH=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5. Codes 6-7 SHALL go to TRAP.
REQ-025 IDLE: all strobes low; Run=1 -> FETCH next cycle.
REQ-026 FETCH: MemReq=1, MemAddrSelect=0, MemWrite=0. In the MemAck cycle, InstructionLatch=1 (same cycle), then -> EXECUTE. Otherwise stay.
REQ-027 EXECUTE: exactly one cycle. InvalidInstruction -> TRAP (TrapCause=0). Else IsMemoryRead|IsMemoryWrite -> MEMORY. Else -> WRITEBACK.
REQ-028 MEMORY: MemReq=1, MemAddrSelect=1, MemWrite=IsMemoryWrite. MemAck -> WRITEBACK.
REQ-029 WRITEBACK: exactly one cycle. PCWrite=1. RegWrite=WritesRegisterFile & ~IsMemoryWrite. PCSelect=2 if IsJump, else 1 if IsBranch&BranchTaken, else 0. RetiredCount+1. Then Run ? FETCH : IDLE.
REQ-030 TRAP: Trap=1, all other strobes low, no exit except Reset.
REQ-031 Latency with zero-wait MemAck: non-memory instruction 3 cycles (FETCH-EXECUTE-WRITEBACK); load/store 4 cycles.
REQ-032 Run falling mid-instruction: the current instruction completes through WRITEBACK, then IDLE.
REQ-033 MemAck in IDLE, EXECUTE, WRITEBACK or TRAP: ignored.
REQ-034 Decoder inputs are sampled only in EXECUTE and WRITEBACK.
REQ-035 RetiredCount wraps 0xFFFFFFFF -> 0x00000000.
REQ-036 MemReq, once asserted, SHALL stay high until the MemAck cycle. Without SEQUENCER_TIMEOUT_EN there is no abort path. With it, the only abort is TRAP per REQ-040.

Reset
REQ-037 Reset high SHALL immediately (asynchronously) force state IDLE, RetiredCount=0, Trap=0, TrapCause=0, all strobes 0, PCSelect=0, timeout counter 0.
REQ-038 Reset during FETCH/MEMORY abandons the request. MemReq SHALL drop without waiting for MemAck.

Configuration
REQ-039 Macro SEQUENCER_TIMEOUT_EN SHALL control the memory-timeout feature.
REQ-040 Defined: an 8+ bit wait counter clears on entry to FETCH/MEMORY and increments each cycle there without MemAck. When it reaches TIMEOUT_CYCLES -> TRAP with TrapCause=1. An ack on the limit cycle wins.
REQ-041 Undefined: no counter; waits indefinitely; TrapCause=0; TIMEOUT_CYCLES ignored.

Verification
REQ-042 Reset, Run=1, MemAck tied 1, ADD-type flags -> State 0,1,2,4,1; RegWrite=1 and PCSelect=0 in the WRITEBACK cycle; RetiredCount=1.
REQ-043 Store with IsMemoryWrite=1, MemAck delayed 3 cycles in MEMORY -> MemReq high 4 cycles, MemWrite=1, MemAddrSelect=1, RegWrite=0 in WRITEBACK.
REQ-044 IsBranch=1, BranchTaken=1 -> PCSelect=1. IsJump=1 -> PCSelect=2. IsBranch=1, BranchTaken=0 -> PCSelect=0.
REQ-045 InvalidInstruction=1 in EXECUTE -> State=5, Trap=1, TrapCause=0 held. Run toggling has no effect. Reset -> State=0.
REQ-046 RetiredCount forced near 0xFFFFFFFF, retire 2 instructions -> count reads 0x00000000 then 0x00000001.
REQ-047 SEQUENCER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, MemAck never asserted in FETCH -> TRAP after 4 cycles, TrapCause=1. Same stimulus with the macro undefined -> stays in FETCH.

Source files
------------

// File: rtl/instruction_sequencer_if.sv
// Memory handshake bundle between the instruction sequencer (master)
// and the memory port (slave).
interface instruction_sequencer_if;
  logic mem_req;
  logic mem_write;
  logic mem_addr_select;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_write,
    output mem_addr_select,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  mem_addr_select,
    output mem_ack
  );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle control FSM stepping each instruction
// through FETCH, EXECUTE, optional MEMORY and WRITEBACK, with a sticky TRAP.
// Optional feature: define SEQUENCER_TIMEOUT_EN to trap when a memory
// handshake waits TIMEOUT_CYCLES cycles without an acknowledge.
module instruction_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
  input  logic                    clk,
  input  logic                    rst,
  instruction_sequencer_if.master mem,
  input  logic                    run,
  input  logic                    invalid_instruction,
  input  logic                    is_memory_read,
  input  logic                    is_memory_write,
  input  logic                    is_branch,
  input  logic                    is_jump,
  input  logic                    branch_taken,
  input  logic                    writes_register_file,
  output logic                    instruction_latch,
  output logic                    pc_write,
  output logic [1:0]              pc_select,
  output logic                    reg_write,
  output logic                    trap,
  output logic                    trap_cause,
  output logic [2:0]              state,
  output logic [31:0]             retired_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  state_e      state_r;
  state_e      next_state_s;
  logic        mem_req_s;
  logic        mem_addr_select_s;
  logic        mem_write_s;
  logic        mem_write_r;
  logic        instruction_latch_s;
  logic        pc_write_s;
  logic        reg_write_s;
  logic [1:0]  pc_select_s;
  logic        retire_s;
  logic        timeout_s;
  logic        cause_timeout_s;
  logic        trap_cause_r;
  logic [31:0] retired_count_r;

`ifdef SEQUENCER_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam int CW     = (CW_RAW > 32'sd8) ? CW_RAW : 32'sd8;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 32'd1);

  logic [CW-1:0] wait_cnt_r;

  // Wait counter: zero outside a handshake, counts each un-acked cycle while staying in FETCH/MEMORY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (((state_r == ST_FETCH) || (state_r == ST_MEMORY)) && (next_state_s == state_r)) begin
      wait_cnt_r <= wait_cnt_r + CW'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // The limit is hit in the last allowed waiting cycle; an ack in that cycle still wins.
  assign timeout_s = (wait_cnt_r == LIMIT_M1);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 32'd0);
  assign timeout_s        = 1'b0;
`endif

  // Next-state and strobe decode; every output defaults low, unknown codes fall into TRAP.
  always_comb begin
    next_state_s        = ST_TRAP;
    mem_req_s           = 1'b0;
    mem_addr_select_s   = 1'b0;
    mem_write_s         = 1'b0;
    instruction_latch_s = 1'b0;
    pc_write_s          = 1'b0;
    reg_write_s         = 1'b0;
    pc_select_s         = 2'd0;
    retire_s            = 1'b0;
    cause_timeout_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (mem.mem_ack) begin
          instruction_latch_s = 1'b1;
          next_state_s        = ST_EXECUTE;
        end else if (timeout_s) begin
          cause_timeout_s = 1'b1;
          next_state_s    = ST_TRAP;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_EXECUTE: begin
        if (invalid_instruction) begin
          next_state_s = ST_TRAP;
        end else if (is_memory_read || is_memory_write) begin
          next_state_s = ST_MEMORY;
        end else begin
          next_state_s = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        mem_req_s         = 1'b1;
        mem_addr_select_s = 1'b1;
        mem_write_s       = mem_write_r;
        if (mem.mem_ack) begin
          next_state_s = ST_WRITEBACK;
        end else if (timeout_s) begin
          cause_timeout_s = 1'b1;
          next_state_s    = ST_TRAP;
        end else begin
          next_state_s = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        pc_write_s  = 1'b1;
        retire_s    = 1'b1;
        reg_write_s = writes_register_file & ~is_memory_write;
        if (is_jump) begin
          pc_select_s = 2'd2;
        end else if (is_branch && branch_taken) begin
          pc_select_s = 2'd1;
        end else begin
          pc_select_s = 2'd0;
        end
        if (run) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_TRAP: begin
        next_state_s = ST_TRAP;
      end
      default: begin
        next_state_s = ST_TRAP;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the store flag in EXECUTE so MEMORY does not depend on decoder inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write_r <= 1'b0;
    end else if (state_r == ST_EXECUTE) begin
      mem_write_r <= is_memory_write;
    end else begin
      mem_write_r <= mem_write_r;
    end
  end

  // Trap cause is recorded on the transition into TRAP and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_cause_r <= 1'b0;
    end else if ((state_r != ST_TRAP) && (next_state_s == ST_TRAP)) begin
      trap_cause_r <= cause_timeout_s;
    end else begin
      trap_cause_r <= trap_cause_r;
    end
  end

  // Retired-instruction counter, free-running modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count_r <= 32'd0;
    end else begin
      retired_count_r <= retired_count_r + {31'd0, retire_s};
    end
  end

  assign mem.mem_req         = mem_req_s;
  assign mem.mem_addr_select = mem_addr_select_s;
  assign mem.mem_write       = mem_write_s;
  assign instruction_latch   = instruction_latch_s;
  assign pc_write            = pc_write_s;
  assign pc_select           = pc_select_s;
  assign reg_write           = reg_write_s;
  assign trap                = (state_r == ST_TRAP);
  assign trap_cause          = trap_cause_r;
  assign state               = state_r;
  assign retired_count       = retired_count_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized scoreboard bench for instruction_sequencer: the driver issues
// instructions with random flags and random memory wait states and pushes the
// architecturally expected outcome; a monitor pops and compares on WRITEBACK/TRAP.
`timescale 1ns/1ps
module tb_instruction_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        invalid_instruction;
  logic        is_memory_read;
  logic        is_memory_write;
  logic        is_branch;
  logic        is_jump;
  logic        branch_taken;
  logic        writes_register_file;
  logic        instruction_latch;
  logic        pc_write;
  logic [1:0]  pc_select;
  logic        reg_write;
  logic        trap;
  logic        trap_cause;
  logic [2:0]  state;
  logic [31:0] retired_count;

  instruction_sequencer_if bus();

  instruction_sequencer #(.TIMEOUT_CYCLES(32'd4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem                  (bus),
    .run                  (run),
    .invalid_instruction  (invalid_instruction),
    .is_memory_read       (is_memory_read),
    .is_memory_write      (is_memory_write),
    .is_branch            (is_branch),
    .is_jump              (is_jump),
    .branch_taken         (branch_taken),
    .writes_register_file (writes_register_file),
    .instruction_latch    (instruction_latch),
    .pc_write             (pc_write),
    .pc_select            (pc_select),
    .reg_write            (reg_write),
    .trap                 (trap),
    .trap_cause           (trap_cause),
    .state                (state),
    .retired_count        (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        is_trap;
    bit        reg_write;
    bit [1:0]  pc_select;
    bit        mem_write;
    int        cycles;
    bit [31:0] count_before;
    bit        idle_after;
  } exp_t;

  exp_t      sb_q[$];
  int        checks = 0;
  int        errors = 0;
  bit [31:0] model_count = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_flags(input bit inv, input bit ld, input bit st, input bit br,
                           input bit jp, input bit bt, input bit wrf);
    invalid_instruction  = inv;
    is_memory_read       = ld;
    is_memory_write      = st;
    is_branch            = br;
    is_jump              = jp;
    branch_taken         = bt;
    writes_register_file = wrf;
  endtask

  task automatic scramble();
    set_flags(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)));
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while ((state !== s) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  // Issue one instruction; expectations come from the instruction class alone.
  task automatic run_instr(input bit drop_run, input bit invalid);
    exp_t e;
    int   kind, fd, md;
    bit   wrf, bt, ld, st, br, jp;
    kind = int'($urandom_range(4, 0));
    wrf  = 1'($urandom_range(1, 0));
    bt   = 1'($urandom_range(1, 0));
    fd   = int'($urandom_range(3, 0));
    md   = int'($urandom_range(3, 0));
    ld   = (kind == 1);
    st   = (kind == 2);
    br   = (kind == 3);
    jp   = (kind == 4);
    e.is_trap      = invalid;
    e.reg_write    = wrf & ~st;
    e.pc_select    = jp ? 2'd2 : ((br & bt) ? 2'd1 : 2'd0);
    e.mem_write    = st;
    e.cycles       = fd + 3 + ((ld | st) ? (md + 1) : 0);
    e.count_before = model_count;
    e.idle_after   = drop_run;
    sb_q.push_back(e);
    if (!invalid) model_count = model_count + 32'd1;
    run = 1'b1;
    wait_state(3'd1, "reach_fetch");
    repeat (fd) @(negedge clk);
    set_flags(invalid, ld, st, br, jp, bt, wrf);
    bus.mem_ack = 1'b1;
    #1 check("latch_on_ack", 32'(instruction_latch), 32'd1);
    @(negedge clk);
    bus.mem_ack = 1'($urandom_range(1, 0));
    if (drop_run) run = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    if (!invalid) begin
      if (ld | st) begin
        for (int i = 0; i < md; i++) begin
          scramble();
          @(negedge clk);
        end
        scramble();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        set_flags(invalid, ld, st, br, jp, bt, wrf);
      end
      bus.mem_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
      bus.mem_ack = 1'b0;
      scramble();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_count = 32'd0;
  endtask

  // Monitor: samples shortly after each falling edge, checks strobes and pops on WRITEBACK/TRAP.
  bit [2:0] prev_state = 3'd0;
  int       lat = 0;
  bit       post_pending = 1'b0;
  exp_t     cur;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_state   = 3'd0;
      lat          = 0;
      post_pending = 1'b0;
    end else begin
      if (post_pending) begin
        check("next_after_wb", 32'(state), cur.idle_after ? 32'd0 : 32'd1);
        check("count_after_wb", retired_count, cur.count_before + 32'd1);
        post_pending = 1'b0;
      end
      if ((state == 3'd1) && (prev_state != 3'd1)) lat = 1;
      else lat++;
      case (state)
        3'd0, 3'd2: check("quiet_strobes", 32'({bus.mem_req, pc_write, reg_write, instruction_latch, trap}), 32'd0);
        3'd1: begin
          check("fetch_bus", 32'({bus.mem_req, bus.mem_addr_select, bus.mem_write}), 32'b100);
          check("fetch_latch", 32'(instruction_latch), 32'(bus.mem_ack));
        end
        3'd3: begin
          if (sb_q.size() > 0)
            check("memory_bus", 32'({bus.mem_req, bus.mem_addr_select, bus.mem_write}),
                  32'({1'b1, 1'b1, sb_q[0].mem_write}));
        end
        3'd4: begin
          if (sb_q.size() == 0) begin
            check("wb_unexpected", 32'(state), 32'd0);
          end else begin
            cur = sb_q.pop_front();
            check("wb_trap_flag", 32'(trap), 32'(cur.is_trap));
            check("wb_pc_write", 32'(pc_write), 32'd1);
            check("wb_reg_write", 32'(reg_write), 32'(cur.reg_write));
            check("wb_pc_select", 32'(pc_select), 32'(cur.pc_select));
            check("wb_count", retired_count, cur.count_before);
            check("wb_mem_req", 32'(bus.mem_req), 32'd0);
            check("latency", 32'(lat), 32'(cur.cycles));
            post_pending = 1'b1;
          end
        end
        3'd5: begin
          if ((prev_state != 3'd5) && (sb_q.size() > 0)) begin
            cur = sb_q.pop_front();
            check("trap_expected", 32'(cur.is_trap), 32'd1);
            check("trap_cause_invalid", 32'(trap_cause), 32'd0);
          end
          check("trap_hold", 32'({trap, bus.mem_req, pc_write, reg_write, instruction_latch}), 32'b10000);
        end
        default: check("illegal_state", 32'(state), 32'd0);
      endcase
      prev_state = state;
    end
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    bus.mem_ack = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", retired_count, 32'd0);
    check("rst_outputs", 32'({trap, trap_cause, bus.mem_req, bus.mem_write, bus.mem_addr_select,
                              instruction_latch, pc_write, reg_write, pc_select}), 32'd0);
    rst = 1'b0;

    // Run low keeps the sequencer idle, even with a stray ack.
    bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold", 32'(state), 32'd0);
    bus.mem_ack = 1'b0;

    // Random instruction stream with occasional Run drops.
    for (int n = 0; n < 40; n++) run_instr((n == 39) || ($urandom_range(4, 0) == 0), 1'b0);
    @(negedge clk);
    check("idle_after_stream", 32'(state), 32'd0);
    check("stream_count", retired_count, model_count);

    // Counter wrap: preload near the top while idle, then retire two.
    force dut.retired_count_r = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.retired_count_r;
    model_count = 32'hFFFF_FFFF;
    check("wrap_preload", retired_count, 32'hFFFF_FFFF);
    run_instr(1'b0, 1'b0);
    run_instr(1'b1, 1'b0);
    @(negedge clk);
    check("wrap_final", retired_count, 32'd1);

    // Reset in the middle of a fetch drops the request at once.
    run = 1'b1;
    wait_state(3'd1, "reset_fetch_reach");
    #1 rst = 1'b1;
    #1 check("rst_drops_req", 32'({bus.mem_req, state}), 32'd0);
    check("rst_clears_count", retired_count, 32'd0);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_count = 32'd0;

    // Fetch with no acknowledge at all.
    run = 1'b1;
    wait_state(3'd1, "timeout_fetch_reach");
`ifdef SEQUENCER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("timeout_waiting", 32'(state), 32'd1);
    end
    @(negedge clk);
    check("timeout_trap_state", 32'(state), 32'd5);
    check("timeout_trap_cause", 32'({trap, trap_cause}), 32'b11);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_timeout_wait", 32'(state), 32'd1);
    end
    check("no_timeout_cause", 32'(trap_cause), 32'd0);
`endif
    do_reset();

    // A few more instructions, then an invalid one traps for good.
    for (int n = 0; n < 5; n++) run_instr(1'b0, 1'b0);
    run_instr(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run = 1'($urandom_range(1, 0));
      bus.mem_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    check("trap_sticky", 32'({state, trap, trap_cause}), 32'({3'd5, 1'b1, 1'b0}));
    check("trap_no_retire", retired_count, model_count);
    do_reset();
    @(negedge clk);
    check("trap_reset_state", 32'({state, trap}), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end
endmodule
